// File: rtl/div_seq_pkg.sv
// Shared constants and types for the sequential MIPS-style divider:
// ALU op codes, FSM state encoding and iteration count.
package div_seq_pkg;

  localparam logic [7:0] EXE_DIV_OP     = 8'b0001_1010;
  localparam logic [7:0] EXE_DIVU_OP    = 8'b0001_1011;
  localparam int         DIV_CYCLES_DEF = 32;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_RUN  = 2'd1,
    DIV_ZERO = 2'd2,
    DIV_DONE = 2'd3
  } div_state_e;

  // Two's-complement negate when n is set; used for magnitudes and sign fix-up.
  function automatic logic [31:0] neg_if(input logic [31:0] v, input logic n);
    return n ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring shift-subtract iteration: shifts the next dividend bit into
// the partial remainder and emits one quotient bit.
module div_step (
  input  logic [31:0] rem_i,
  input  logic [31:0] quo_i,
  input  logic [31:0] den_i,
  output logic [31:0] rem_o,
  output logic [31:0] quo_o
);

  logic [32:0] trial, diff;

  // trial < 2*den, so a borrow shows up as bit 32 of the 33-bit difference
  assign trial = {rem_i, quo_i[31]};
  assign diff  = trial - {1'b0, den_i};
  assign rem_o = diff[32] ? trial[31:0] : diff[31:0];
  assign quo_o = {quo_i[30:0], ~diff[32]};

endmodule

// File: rtl/div_seq.sv
// Multi-cycle 32-bit signed/unsigned divider for the EX stage; stalls the
// pipeline while iterating and strobes {HI=rem, LO=quo} for one cycle.
module div_seq
  import div_seq_pkg::*;
#(
  parameter int DIV_CYCLES = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  alucontrol,
  input  logic        valid_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic        flush_i,
  output logic        stall_o,
  output logic        hilo_we_o,
  output logic [63:0] hilo_o
);

  div_state_e  state_q, state_d;
  logic [5:0]  cnt_q;
  logic [31:0] rem_q, quo_q, den_q, rem_nx, quo_nx;
  logic        negq_q, negr_q;
  logic        start, is_signed;
  logic [31:0] a_mag, b_mag;

  assign start     = valid_i & ((alucontrol == EXE_DIV_OP) | (alucontrol == EXE_DIVU_OP));
  assign is_signed = (alucontrol == EXE_DIV_OP);
  assign a_mag     = neg_if(a_i, is_signed & a_i[31]);
  assign b_mag     = neg_if(b_i, is_signed & b_i[31]);

  div_step u_step (
    .rem_i (rem_q),
    .quo_i (quo_q),
    .den_i (den_q),
    .rem_o (rem_nx),
    .quo_o (quo_nx)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      DIV_IDLE: if (start) state_d = (b_i != 32'd0) ? DIV_RUN : DIV_ZERO;
      DIV_RUN:  if (cnt_q == 6'(DIV_CYCLES - 1)) state_d = DIV_DONE;
      DIV_ZERO: state_d = DIV_DONE;
      DIV_DONE: state_d = DIV_IDLE;
      default:  state_d = DIV_IDLE;
    endcase
    if (flush_i) state_d = DIV_IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= DIV_IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      rem_q  <= '0;
      quo_q  <= '0;
      den_q  <= '0;
      negq_q <= 1'b0;
      negr_q <= 1'b0;
    end else begin
      case (state_q)
        DIV_IDLE: if (start && !flush_i) begin
          cnt_q <= '0;
          if (b_i != 32'd0) begin
            rem_q  <= '0;
            quo_q  <= a_mag;
            den_q  <= b_mag;
            negq_q <= is_signed & (a_i[31] ^ b_i[31]);
            negr_q <= is_signed & a_i[31];
          end else begin
            // divide-by-zero result is preloaded so DONE needs no special path
            rem_q  <= a_i;
            quo_q  <= '1;
            den_q  <= '0;
            negq_q <= 1'b0;
            negr_q <= 1'b0;
          end
        end
        DIV_RUN: begin
          rem_q <= rem_nx;
          quo_q <= quo_nx;
          cnt_q <= cnt_q + 6'd1;
        end
        default: ;
      endcase
    end
  end

  assign stall_o   = ~rst & (((state_q == DIV_IDLE) & start & ~flush_i) |
                             (state_q == DIV_RUN) | (state_q == DIV_ZERO));
  assign hilo_we_o = ~rst & ~flush_i & (state_q == DIV_DONE);
  assign hilo_o    = hilo_we_o ? {neg_if(rem_q, negr_q), neg_if(quo_q, negq_q)} : 64'd0;

endmodule

// File: tb/tb_div_seq.sv
// Scoreboard bench for div_seq: stimulus pushes expected {HI,LO} and write
// cycle; a monitor pops on every hilo_we_o and compares.
module tb_div_seq;
  import div_seq_pkg::*;

  logic        clk, rst, valid_i, flush_i;
  logic [7:0]  alucontrol;
  logic [31:0] a_i, b_i;
  logic        stall_o, hilo_we_o;
  logic [63:0] hilo_o;

  div_seq dut (
    .clk(clk), .rst(rst), .alucontrol(alucontrol), .valid_i(valid_i),
    .a_i(a_i), .b_i(b_i), .flush_i(flush_i),
    .stall_o(stall_o), .hilo_we_o(hilo_we_o), .hilo_o(hilo_o)
  );

  typedef struct { logic [63:0] hilo; int cyc; } exp_t;
  exp_t sbq[$];
  int errors = 0;
  int checks = 0;
  int cyc = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference: plain 64-bit integer division (truncating, remainder follows dividend)
  function automatic logic [63:0] model(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    if (b == 32'd0) return {a, 32'hFFFF_FFFF};
    if (op == EXE_DIV_OP) begin
      sa = {{32{a[31]}}, a};
      sb = {{32{b[31]}}, b};
    end else begin
      sa = {32'd0, a};
      sb = {32'd0, b};
    end
    q = sa / sb;
    r = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, req);
    end
  endtask

  // Monitor: every write must match the oldest expectation, in value and cycle
  always @(negedge clk) begin
    if (!rst && hilo_we_o) begin
      exp_t e;
      checks++;
      if (sbq.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write cyc=%0d actual=%h required=none", cyc, hilo_o);
      end else begin
        e = sbq.pop_front();
        if (hilo_o !== e.hilo || cyc != e.cyc) begin
          errors++;
          $display("FAIL hilo cyc=%0d actual=%h required=%h at cyc %0d", cyc, hilo_o, e.hilo, e.cyc);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic drop_start();
    valid_i = 1'b0; alucontrol = 8'd0; a_i = $urandom; b_i = $urandom;
  endtask

  // Issue one divide when idle; checks stall each cycle until the write cycle
  task automatic issue(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b);
    int s, lat;
    exp_t e;
    s = cyc; lat = (b == 32'd0) ? 2 : 33;
    alucontrol = op; valid_i = 1'b1; a_i = a; b_i = b;
    e.hilo = model(op, a, b); e.cyc = s + lat;
    sbq.push_back(e);
    @(negedge clk); chk("stall_start", 64'(stall_o), 64'd1);
    step(); drop_start();
    for (int k = 1; k <= lat; k++) begin
      @(negedge clk); chk("stall_busy", 64'(stall_o), 64'(k < lat));
      step();
    end
  endtask

  initial begin
    int s;
    exp_t e;
    rst = 1'b1; valid_i = 1'b0; flush_i = 1'b0; alucontrol = 8'd0; a_i = '0; b_i = '0;
    step();
    @(negedge clk);
    chk("rst_outs", {stall_o, hilo_we_o, hilo_o}, 66'd0);
    step(); rst = 1'b0;
    @(negedge clk);
    chk("post_rst_outs", {stall_o, hilo_we_o, hilo_o}, 66'd0);
    step();

    // directed cases
    issue(EXE_DIVU_OP, 32'd100, 32'd7);
    issue(EXE_DIV_OP,  32'hFFFF_FFF9, 32'd2);
    issue(EXE_DIVU_OP, 32'hFFFF_FFF9, 32'd2);
    issue(EXE_DIV_OP,  32'h8000_0000, 32'hFFFF_FFFF);
    issue(EXE_DIV_OP,  32'h0000_1234, 32'd0);
    issue(EXE_DIVU_OP, 32'hDEAD_BEEF, 32'hFFFF_FFFF);

    // flush at cycle 10, restart at cycle 12 completes at 45
    s = cyc;
    alucontrol = EXE_DIVU_OP; valid_i = 1'b1; a_i = 32'd1000; b_i = 32'd3;
    step(); drop_start();
    while (cyc < s + 10) step();
    flush_i = 1'b1;
    step(); flush_i = 1'b0;
    @(negedge clk); chk("flush_stall", 64'(stall_o), 64'd0);
    step();
    issue(EXE_DIV_OP, 32'hFFFF_FC18, 32'd7);

    // flush during DONE suppresses the write
    s = cyc;
    alucontrol = EXE_DIVU_OP; valid_i = 1'b1; a_i = 32'd50; b_i = 32'd5;
    step(); drop_start();
    while (cyc < s + 33) step();
    flush_i = 1'b1;
    @(negedge clk); chk("flush_done_we", 64'(hilo_we_o), 64'd0);
    step(); flush_i = 1'b0;
    step();

    // reset at cycle 5 abandons the divide
    s = cyc;
    alucontrol = EXE_DIV_OP; valid_i = 1'b1; a_i = 32'd77; b_i = 32'd9;
    step(); drop_start();
    while (cyc < s + 5) step();
    rst = 1'b1;
    @(negedge clk); chk("rst_mid_outs", {stall_o, hilo_we_o, hilo_o}, 66'd0);
    step(); rst = 1'b0;
    @(negedge clk); chk("rst_mid_after", {stall_o, hilo_we_o, hilo_o}, 66'd0);
    repeat (40) step();

    // start held through DONE: second accept only once back in IDLE
    s = cyc;
    alucontrol = EXE_DIVU_OP; valid_i = 1'b1; a_i = 32'd100; b_i = 32'd7;
    e.hilo = model(EXE_DIVU_OP, 32'd100, 32'd7);
    e.cyc = s + 33; sbq.push_back(e);
    e.cyc = s + 67; sbq.push_back(e);
    while (cyc < s + 33) step();
    @(negedge clk); chk("held_done_stall", 64'(stall_o), 64'd0);
    step();
    @(negedge clk); chk("held_idle_stall", 64'(stall_o), 64'd1);
    step(); drop_start();
    while (cyc < s + 69) step();

    // randomized operands
    for (int i = 0; i < 30; i++) begin
      logic [7:0]  op;
      logic [31:0] a, b;
      op = ($urandom_range(0, 1) == 0) ? EXE_DIV_OP : EXE_DIVU_OP;
      a  = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
      case ($urandom_range(0, 9))
        0:       b = 32'd0;
        1:       b = 32'($urandom_range(1, 15));
        2:       b = 32'hFFFF_FFFF;
        3:       b = 32'h8000_0000;
        default: b = $urandom;
      endcase
      issue(op, a, b);
    end

    repeat (3) step();
    chk("sb_empty", 64'(sbq.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/div_seq.md
DIV_SEQ -- requirements
Module: div_seq

Interface
REQ-001 Parameter DIV_CYCLES, default 32, number of shift-subtract iterations; fixed at 32 for 32-bit operands.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 alucontrol  input  8  ALU op from the ALU decoder; start when it equals EXE_DIV_OP (signed) or EXE_DIVU_OP (unsigned).
REQ-005 valid_i  input  1  the EX-stage instruction is valid; start also requires valid_i=1.
REQ-006 a_i  input  32  dividend (rs value).
REQ-007 b_i  input  32  divisor (rt value).
REQ-008 flush_i  input  1  pipeline flush/annul; aborts any divide in progress.
REQ-009 stall_o  output  1  EX stall request to the hazard unit.
REQ-010 hilo_we_o  output  1  one-cycle HI/LO write strobe.
REQ-011 hilo_o  output  64  {HI=remainder, LO=quotient}; valid only while hilo_we_o=1.

Function
REQ-012 The FSM SHALL have states IDLE, RUN, ZERO and DONE.
REQ-013 In IDLE with start=1 and flush_i=0, the block SHALL latch the operands and the signed flag, then go to RUN if b_i!=0, else to ZERO.
REQ-014 Start SHALL be sampled only in IDLE; alucontrol and valid_i SHALL be ignored in every other state.
REQ-015 RUN SHALL perform one restoring shift-subtract step per cycle on the magnitudes for DIV_CYCLES cycles, counted by a 6-bit counter, then go to DONE.
REQ-016 ZERO SHALL last one cycle and then go to DONE.
REQ-017 DONE SHALL last one cycle, assert hilo_we_o=1 with the final hilo_o, and return to IDLE.
REQ-018 Latency: with start accepted in cycle 0, RUN occupies cycles 1..32 and DONE is cycle 33; divide-by-zero reaches DONE in cycle 2.
REQ-019 stall_o SHALL be the combinational function (IDLE & start & ~flush_i) | RUN | ZERO, and SHALL be 0 in DONE so the instruction retires with the write.
REQ-020 Signed mode SHALL divide absolute values, negate the quotient when the operand signs differ, and give the remainder the sign of the dividend.
REQ-021 Signed 0x80000000 / 0xFFFFFFFF SHALL give LO=0x80000000 and HI=0 (32-bit wrap), with no special case needed.
REQ-022 Unsigned mode SHALL treat both operands as 32-bit unsigned values.
REQ-023 Divide-by-zero SHALL produce LO=0xFFFFFFFF and HI=the latched dividend.
REQ-024 flush_i=1 in any state SHALL force IDLE on the next edge with no hilo_we_o, including flush in DONE, which SHALL suppress that cycle's write.
REQ-025 hilo_we_o SHALL never be asserted outside DONE, and SHALL be asserted at most once per accepted start.

Reset
REQ-026 rst=1 SHALL, on the next edge, set state=IDLE and clear the counter and operand/partial registers.
REQ-027 During and immediately after reset: stall_o=0, hilo_we_o=0, hilo_o=0.
REQ-028 Reset mid-operation SHALL abandon the divide with no write.

Structure
REQ-029 FSM state encodings (DIV_IDLE, DIV_RUN, DIV_ZERO, DIV_DONE) and DIV_CYCLES SHALL live in defines.vh next to EXE_DIV_OP and EXE_DIVU_OP.
REQ-030 The single-iteration compare/subtract/shift step SHALL be the sub-module div_step (combinational, 33-bit subtract); div_seq SHALL hold the FSM, counter, sign fix-up and output registers.

Verification
REQ-031 Unsigned 100/7, start at cycle 0 -> stall_o=1 for cycles 0..32, hilo_we_o=1 at cycle 33, hilo_o={HI=2, LO=14}.
REQ-032 Signed -7/2 (0xFFFFFFF9/2) -> at cycle 33 LO=0xFFFFFFFD and HI=0xFFFFFFFF; the same operands with EXE_DIVU_OP -> LO=0x7FFFFFFC, HI=1.
REQ-033 Signed 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0.
REQ-034 Divisor 0, dividend 0x1234 -> hilo_we_o at cycle 2 with LO=0xFFFFFFFF and HI=0x1234; stall_o=1 in cycles 0..1 only.
REQ-035 flush_i pulsed at cycle 10 of a divide -> IDLE at cycle 11, stall_o=0, no hilo_we_o; a new start at cycle 12 completes at cycle 45.
REQ-036 rst at cycle 5 of a divide -> all outputs 0 from cycle 6, no write; a start held during DONE is not accepted until IDLE.
